// File: rtl/paddsb_sched.sv
// paddsb_sched: shared nibble-serial packed saturating-add engine.
// Two requesters are arbitrated round-robin. The winner's operands are latched
// and a 4-bit signed saturating adder is stepped across the four nibbles,
// LANES nibbles per compute cycle.
// Optional build macro PADDSB_STICKY_OVFL_EN adds ovfl_clr / ovfl_sticky,
// a register that accumulates the per-nibble overflow flags across operations.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for a request; grants and latches the winner's operands
// S_COMP | computing nibble group r_k (0..C-1); busy is high
module paddsb_sched #(
  parameter int LANES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [15:0] rs0,
  input  logic [15:0] rt0,
  input  logic [15:0] rs1,
  input  logic [15:0] rt1,
`ifdef PADDSB_STICKY_OVFL_EN
  input  logic        ovfl_clr,
  output logic [3:0]  ovfl_sticky,
`endif
  output logic [1:0]  gnt,
  output logic        busy,
  output logic        done,
  output logic        done_id,
  output logic [15:0] rd,
  output logic [3:0]  ovfl
);

  localparam int         C      = 4 / LANES;
  localparam logic [1:0] K_LAST = 2'(C - 1);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
      $error("paddsb_sched: LANES must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic {
    S_IDLE = 1'b0,
    S_COMP = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_k;
  logic [1:0]  w_k_nxt;
  logic        r_last;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic        r_id;
  logic [15:0] r_res;
  logic [3:0]  r_ov;
  logic [15:0] w_res_nxt;
  logic [3:0]  w_ov_nxt;
  logic [1:0]  w_gnt;
  logic        w_busy;
  logic        w_fin;
  logic        r_done;
  logic        r_done_id;
  logic [15:0] r_rd;
  logic [3:0]  r_ovfl;

  // Next-state, grant selection and busy/finish decode.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_gnt       = 2'b00;
    w_busy      = 1'b0;
    w_fin       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req != 2'b00) begin
          // On contention the requester not granted last wins.
          if (req == 2'b11) w_gnt = r_last ? 2'b01 : 2'b10;
          else              w_gnt = req;
          w_state_nxt = S_COMP;
          w_k_nxt     = 2'd0;
        end
      end
      S_COMP: begin
        w_busy = 1'b1;
        if (r_k == K_LAST) begin
          w_fin       = 1'b1;
          w_state_nxt = S_IDLE;
          w_k_nxt     = 2'd0;
        end else begin
          w_k_nxt = r_k + 2'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_k_nxt     = 2'd0;
      end
    endcase
  end

  // Saturating add of the nibble group selected by r_k, merged into the result.
  always_comb begin
    int         v_idx;
    logic [3:0] v_a;
    logic [3:0] v_b;
    logic [3:0] v_s;
    w_res_nxt = r_res;
    w_ov_nxt  = r_ov;
    v_idx     = 0;
    v_a       = 4'd0;
    v_b       = 4'd0;
    v_s       = 4'd0;
    for (int l = 0; l < LANES; l++) begin
      v_idx = int'(r_k) * LANES + l;
      v_a   = r_a[v_idx*4 +: 4];
      v_b   = r_b[v_idx*4 +: 4];
      v_s   = v_a + v_b;
      if (!v_a[3] && !v_b[3] && v_s[3]) begin
        w_res_nxt[v_idx*4 +: 4] = 4'b0111;
        w_ov_nxt[v_idx]         = 1'b1;
      end else if (v_a[3] && v_b[3] && !v_s[3]) begin
        w_res_nxt[v_idx*4 +: 4] = 4'b1000;
        w_ov_nxt[v_idx]         = 1'b1;
      end else begin
        w_res_nxt[v_idx*4 +: 4] = v_s;
        w_ov_nxt[v_idx]         = 1'b0;
      end
    end
  end

  // State, operand latch, working result and published outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_k       <= 2'd0;
      r_last    <= 1'b1;
      r_a       <= 16'h0000;
      r_b       <= 16'h0000;
      r_id      <= 1'b0;
      r_res     <= 16'h0000;
      r_ov      <= 4'h0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
      r_rd      <= 16'h0000;
      r_ovfl    <= 4'h0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_done  <= w_fin;
      if (w_gnt != 2'b00) begin
        r_a    <= w_gnt[1] ? rs1 : rs0;
        r_b    <= w_gnt[1] ? rt1 : rt0;
        r_id   <= w_gnt[1];
        r_last <= w_gnt[1];
        r_res  <= 16'h0000;
        r_ov   <= 4'h0;
      end else if (r_state == S_COMP) begin
        r_res <= w_res_nxt;
        r_ov  <= w_ov_nxt;
      end
      // Outputs are published whole, only when the last nibble group lands.
      if (w_fin) begin
        r_rd      <= w_res_nxt;
        r_ovfl    <= w_ov_nxt;
        r_done_id <= r_id;
      end
    end
  end

`ifdef PADDSB_STICKY_OVFL_EN
  logic [3:0] r_sticky;

  // Accumulate overflow flags at each completion; a clear keeps only the new flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky <= 4'h0;
    end else if (ovfl_clr) begin
      r_sticky <= w_fin ? w_ov_nxt : 4'h0;
    end else if (w_fin) begin
      r_sticky <= r_sticky | w_ov_nxt;
    end
  end

  assign ovfl_sticky = r_sticky;
`endif

  assign gnt     = rst ? 2'b00 : w_gnt;
  assign busy    = w_busy;
  assign done    = r_done;
  assign done_id = r_done_id;
  assign rd      = r_rd;
  assign ovfl    = r_ovfl;

endmodule

// File: tb/tb_paddsb_sched.sv
// Bench for paddsb_sched: cycle-level scheduling model plus arithmetic
// reference checked on every cycle, directed test-plan cases and random traffic.
module tb_paddsb_sched;
  localparam int LANES = 1;
  localparam int C     = 4 / LANES;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [15:0] rs0 = 16'h0, rt0 = 16'h0, rs1 = 16'h0, rt1 = 16'h0;
  logic [1:0]  gnt;
  logic        busy, done, done_id;
  logic [15:0] rd;
  logic [3:0]  ovfl;
`ifdef PADDSB_STICKY_OVFL_EN
  logic        ovfl_clr = 1'b0;
  logic [3:0]  ovfl_sticky;
`endif

  paddsb_sched #(.LANES(LANES)) dut (
    .clk(clk), .rst(rst), .req(req),
    .rs0(rs0), .rt0(rt0), .rs1(rs1), .rt1(rt1),
`ifdef PADDSB_STICKY_OVFL_EN
    .ovfl_clr(ovfl_clr), .ovfl_sticky(ovfl_sticky),
`endif
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .rd(rd), .ovfl(ovfl)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference add: each nibble as a signed integer, sum clamped to [-8,7].
  function automatic logic [19:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic [3:0]  f;
    int sa, sb, s;
    r = 16'h0;
    f = 4'h0;
    for (int i = 0; i < 4; i++) begin
      sa = int'(a[4*i +: 4]);
      sb = int'(b[4*i +: 4]);
      if (sa > 7) sa = sa - 16;
      if (sb > 7) sb = sb - 16;
      s = sa + sb;
      if (s > 7) begin
        s = 7;
        f[i] = 1'b1;
      end else if (s < -8) begin
        s = -8;
        f[i] = 1'b1;
      end
      r[4*i +: 4] = 4'(s);
    end
    return {f, r};
  endfunction

  // Model state: m_rem counts compute cycles left for the op in flight.
  bit          m_valid = 0;
  int          m_rem   = 0;
  logic        m_last  = 1'b1;
  logic        m_done  = 1'b0;
  logic [15:0] m_a = 16'h0, m_b = 16'h0, m_rd = 16'h0;
  logic        m_id = 1'b0, m_did = 1'b0;
  logic [3:0]  m_ov = 4'h0, m_sticky = 4'h0;

  // Compare on the falling edge, then advance the model across the next rising edge.
  always @(negedge clk) begin
    logic [1:0]  eg;
    logic [19:0] r;
    eg = 2'b00;
    if (!rst && m_rem == 0 && req != 2'b00)
      eg = (req == 2'b11) ? (m_last ? 2'b01 : 2'b10) : req;
    if (m_valid) begin
      chk("gnt", gnt, eg);
      chk("busy", busy, (m_rem > 0));
      chk("done", done, m_done);
      chk("rd", rd, m_rd);
      chk("ovfl", ovfl, m_ov);
      chk("done_id", done_id, m_did);
`ifdef PADDSB_STICKY_OVFL_EN
      chk("ovfl_sticky", ovfl_sticky, m_sticky);
`endif
    end
    if (rst) begin
      m_valid  = 1;
      m_rem    = 0;
      m_last   = 1'b1;
      m_done   = 1'b0;
      m_rd     = 16'h0;
      m_ov     = 4'h0;
      m_did    = 1'b0;
      m_sticky = 4'h0;
    end else if (m_valid) begin
      m_done = (m_rem == 1);
      if (m_done) begin
        r     = ref_add(m_a, m_b);
        m_rd  = r[15:0];
        m_ov  = r[19:16];
        m_did = m_id;
      end
`ifdef PADDSB_STICKY_OVFL_EN
      if (ovfl_clr) m_sticky = m_done ? m_ov : 4'h0;
      else if (m_done) m_sticky = m_sticky | m_ov;
`endif
      if (m_rem > 0) m_rem--;
      if (eg != 2'b00) begin
        m_id   = eg[1];
        m_last = eg[1];
        m_a    = eg[1] ? rs1 : rs0;
        m_b    = eg[1] ? rt1 : rt0;
        m_rem  = C;
      end
    end
  end

  task automatic do_op(input logic id, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp_rd, input logic [3:0] exp_ov);
    bit got;
    int lat;
    @(posedge clk); #1;
    req = id ? 2'b10 : 2'b01;
    if (id) begin rs1 = a; rt1 = b; end
    else    begin rs0 = a; rt0 = b; end
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (gnt != 2'b00) got = 1;
    end
    if (!got) begin
      chk("gnt_timeout", 32'd0, 32'd1);
      req = 2'b00;
      return;
    end
    chk("op_gnt", gnt, id ? 32'd2 : 32'd1);
    @(posedge clk); #1;
    req = 2'b00;
    rs0 = $urandom; rt0 = $urandom; rs1 = $urandom; rt1 = $urandom;
    got = 0;
    lat = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      lat++;
      if (done) got = 1;
    end
    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
      return;
    end
    chk("op_latency", lat, C + 1);
    chk("op_rd", rd, exp_rd);
    chk("op_ovfl", ovfl, exp_ov);
    chk("op_done_id", done_id, id);
  endtask

  initial begin
    logic [1:0] g[4];
    logic       dn[4];
    int         n, ndone;
    bit         got;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    do_op(1'b0, 16'h1234, 16'h4321, 16'h5555, 4'b0000);
    do_op(1'b0, 16'h7171, 16'h1111, 16'h7272, 4'b1010);
    do_op(1'b1, 16'h8888, 16'h8888, 16'h8888, 4'b1111);

    // Round-robin under continuous contention from reset.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; req = 2'b11;
    n = 0;
    for (int t = 0; t < 40 && n < 4; t++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin
        g[n]  = gnt;
        dn[n] = done;
        n++;
      end
    end
    @(posedge clk); #1 req = 2'b00;
    chk("rr_count", n, 4);
    if (n == 4) begin
      chk("rr_g0", g[0], 2'b01);
      chk("rr_g1", g[1], 2'b10);
      chk("rr_g2", g[2], 2'b01);
      chk("rr_g3", g[3], 2'b10);
      chk("rr_done1", dn[1], 1'b1);
      chk("rr_done3", dn[3], 1'b1);
    end
    repeat (8) @(posedge clk);

    // Reset abort in the second cycle after the grant.
    #1 req = 2'b01; rs0 = 16'h1111; rt0 = 16'h2222;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (gnt != 2'b00) got = 1;
    end
    chk("abort_gnt", got, 1'b1);
    @(posedge clk); #1 req = 2'b00;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_rd", rd, 16'h0000);
    chk("abort_done", done, 1'b0);
    ndone = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);

    do_op(1'b0, 16'h7171, 16'h1111, 16'h7272, 4'b1010);
    do_op(1'b0, 16'h0007, 16'h0001, 16'h0007, 4'b0001);
`ifdef PADDSB_STICKY_OVFL_EN
    @(negedge clk);
    chk("sticky_acc", ovfl_sticky, 4'b1011);
    @(posedge clk); #1 ovfl_clr = 1'b1;
    @(posedge clk); #1 ovfl_clr = 1'b0;
    @(negedge clk);
    chk("sticky_clr", ovfl_sticky, 4'b0000);
`endif

    // Random traffic with occasional resets.
    for (int t = 0; t < 1500; t++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 79) == 0);
      req = 2'($urandom);
      rs0 = 16'($urandom); rt0 = 16'($urandom);
      rs1 = 16'($urandom); rt1 = 16'($urandom);
`ifdef PADDSB_STICKY_OVFL_EN
      ovfl_clr = ($urandom_range(0, 15) == 0);
`endif
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req = 2'b00;
`ifdef PADDSB_STICKY_OVFL_EN
    ovfl_clr = 1'b0;
`endif
    repeat (10) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/paddsb_sched.md
Name: paddsb_sched

Overview:
- Shared, nibble-serial packed saturating-add engine for the WISC datapath.
- Two requesters share one engine: port 0 (execute stage) and port 1 (secondary/debug requester).
- Arbitrates between them round-robin, latches the operands, and steps a 4-bit signed saturating adder across the four nibbles.
- Returns a 16-bit packed result plus per-nibble overflow flags with a done pulse.

Parameters:
- LANES, 1, nibbles processed per compute cycle; legal values 1, 2, 4; compute cycles C = 4/LANES.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- req  input  2  request per requester; level, held until granted
- rs0  input  16  requester 0 operand A
- rt0  input  16  requester 0 operand B
- rs1  input  16  requester 1 operand A
- rt1  input  16  requester 1 operand B
- gnt  output  2  one-hot, one-cycle pulse; operands sampled this cycle
- busy  output  1  high while compute states are active
- done  output  1  one-cycle pulse; rd/ovfl/done_id valid
- done_id  output  1  requester index of the completed op
- rd  output  16  packed saturated sum
- ovfl  output  4  per-nibble saturation flags; bit i corresponds to nibble i (bits 4i+3:4i)

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, rst.
- Reset values:
  - gnt=0, busy=0, done=0, done_id=0, rd=0x0000, ovfl=0.
  - RR pointer=1, so requester 0 wins the first tie.
  - State=IDLE.
- State machine: IDLE -> COMP(k), k=0..C-1 -> IDLE.
- Grant (IDLE only):
  - Single requester: grant it.
  - Both requesting: grant the requester not granted last; update pointer on each grant.
  - On a grant, latch (rs,rt) of the winner and its id into internal registers.
  - Next state COMP(0).
- COMP(k):
  - Computes nibbles k*LANES .. k*LANES+LANES-1 from the latched operands into an internal result register.
  - busy=1 in every COMP cycle.
  - No grants while in COMP.
- Completion:
  - After COMP(C-1), the FSM returns to IDLE.
  - In that first IDLE cycle: done=1; rd, ovfl, done_id take the new values.
  - A new grant may occur in the same cycle as done.
- Latency: gnt at cycle T -> done at T+C+1 (LANES=1: T+5). Back-to-back throughput: one op per C+1 cycles.
- rd/ovfl/done_id hold until the next done; they are never partially updated.
- Nibble arithmetic, s = a+b on 4-bit two's complement:
  - a,b both non-negative and s negative -> 4'b0111, flag=1.
  - a,b both negative and s non-negative -> 4'b1000, flag=1.
  - Otherwise s, flag=0.
  - No carry between nibbles.
- Operands on rs/rt ports are don't-care except in the grant cycle. Changing them mid-operation has no effect.
- req deasserted while ungranted: no grant, no state change.
- rst mid-operation: abort immediately; no done for the aborted op; all outputs return to reset values.
- Illegal LANES (not 1/2/4): elaboration error.

Optional Feature:
- Macro: PADDSB_STICKY_OVFL_EN.
- With the macro:
  - Adds input ovfl_clr (1) and output ovfl_sticky (4).
  - On each done, ovfl_sticky |= ovfl.
  - ovfl_clr=1 clears it next edge; if clr and done coincide, the new value is the new ovfl only.
  - Reset value is 0.
- Without the macro: ports absent, no sticky register.

Test Plan:
- Basic add, LANES=1: req=01, rs0=0x1234, rt0=0x4321 -> gnt=01 at T, busy T+1..T+4, done at T+5, rd=0x5555, ovfl=0000, done_id=0.
- Positive saturation: rs0=0x7171, rt0=0x1111 -> rd=0x7272, ovfl=4'b1010.
- Negative saturation: rs1=0x8888, rt1=0x8888 via req=10 -> rd=0x8888, ovfl=4'b1111, done_id=1.
- Round-robin contention: req=11 held continuously from reset -> grants alternate 01,10,01,10, each grant coinciding with the prior op's done cycle.
- Reset abort: rst asserted at T+2 of an op -> no done pulse; rd=0x0000, busy=0 next cycle; the next request is granted normally.
- LANES=4 build, plus sticky-overflow build with PADDSB_STICKY_OVFL_EN:
  - LANES=4: 0x7171+0x1111 -> done at T+2.
  - Sticky: op with ovfl 1010, then op with ovfl 0001 -> ovfl_sticky=1011; ovfl_clr pulse -> 0000.
